// File: rtl/mp_add_seq.sv
// Multi-word adder/subtractor: one shared 16-bit CLA, one word per cycle, LSW first.
// Ports: valid/ready request (op_sub, dina, dinb), valid/ready result (sum, cout, ovf, zero), busy.

module full_adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);
  logic [15:0] g, p, c;
  logic [3:0]  gg, pg;
  logic [4:0]  gc;

  always_comb begin
    g = a & b;
    p = a ^ b;
    gc = '0;
    c = '0;
    gg = '0;
    pg = '0;
    gc[0] = cin;
    // Nibble generate/propagate feed a 4-group lookahead carry chain.
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
      gc[k+1] = gg[k] | (pg[k] & gc[k]);
    end
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    s = p ^ c;
    cout = gc[4];
  end
endmodule

module mp_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op_sub,
  input  logic [16*WORDS-1:0]   dina,
  input  logic [16*WORDS-1:0]   dinb,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   sum,
  output logic                  cout,
  output logic                  ovf,
  output logic                  zero,
  output logic                  busy
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e state_q, state_d;
  logic [WORDS-1:0][15:0] a_q, a_d;
  logic [WORDS-1:0][15:0] b_q, b_d;
  logic [WORDS-1:0][15:0] res_q, res_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d;
  logic cout_q, cout_d;
  logic ovf_q, ovf_d;

  logic [15:0] fa_s;
  logic        fa_co;

  full_adder16 u_fa (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    idx_d = idx_q;
    carry_d = carry_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d = dina;
          // Subtract as A + ~B + 1: the +1 enters as the initial carry.
          b_d = op_sub ? ~dinb : dinb;
          carry_d = op_sub;
          idx_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[idx_q] = fa_s;
        carry_d = fa_co;
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST) begin
          idx_d = '0;
          cout_d = fa_co;
          ovf_d = (a_q[WORDS-1][15] == b_q[WORDS-1][15])
               && (fa_s[15] != a_q[WORDS-1][15]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      idx_q <= '0;
      carry_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      idx_q <= idx_d;
      carry_q <= carry_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy = (state_q != IDLE);
  assign sum = res_q;
  assign cout = cout_q;
  assign ovf = ovf_q;
  // Flags are only defined with a valid result; gating keeps zero low at reset.
  assign zero = out_valid && ~|res_q;
endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq with WORDS=4.
// Vector table plus hold, mid-run reset and back-to-back sequences.

module tb_mp_add_seq;
  localparam int W = 4;
  localparam int N = 16 * W;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, op_sub;
  logic [N-1:0] dina, dinb, sum;
  logic out_valid, out_ready;
  logic cout, ovf, zero, busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mp_add_seq #(.WORDS(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .dina      (dina),
    .dinb      (dinb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .busy      (busy)
  );

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic [N-1:0] s;
    logic         co;
    logic         ov;
    logic         z;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [N-1:0] act,
                       input logic [N-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"}, N'(in_ready), N'(1));
    check({tag, ".out_valid"}, N'(out_valid), N'(0));
    check({tag, ".busy"}, N'(busy), N'(0));
    check({tag, ".sum"}, sum, '0);
    check({tag, ".cout"}, N'(cout), N'(0));
    check({tag, ".ovf"}, N'(ovf), N'(0));
    check({tag, ".zero"}, N'(zero), N'(0));
  endtask

  // Drive one op right after a clock edge, expect accept on the next edge.
  task automatic run_op(input vec_t v, input string tag);
    int lat;
    check({tag, ".in_ready"}, N'(in_ready), N'(1));
    in_valid = 1'b1;
    op_sub = v.sub;
    dina = v.a;
    dinb = v.b;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dina = ~v.a;
    dinb = ~v.b;
    op_sub = ~v.sub;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".latency"}, N'(lat), N'(W));
    check({tag, ".sum"}, sum, v.s);
    check({tag, ".cout"}, N'(cout), N'(v.co));
    check({tag, ".ovf"}, N'(ovf), N'(v.ov));
    check({tag, ".zero"}, N'(zero), N'(v.z));
    @(posedge clk);
    #1;
    check({tag, ".drained"}, N'(out_valid), N'(0));
  endtask

  logic [N-1:0] held;
  int acc, res, cyc;
  int acc_cyc[3];
  vec_t bb[3];

  initial begin
    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                64'h0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{64'h0, 64'h1, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                64'h2222_2222_2222_2211, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{64'h5, 64'h5, 1'b1,
                64'h0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                64'h0, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{64'h0, 64'h8000_0000_0000_0000, 1'b1,
                64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    op_sub = 1'b0;
    dina = '0;
    dinb = '0;
    out_ready = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Result held while consumer stalls; inputs wiggle meanwhile.
    in_valid = 1'b1;
    op_sub = 1'b0;
    dina = 64'hFFFF_FFFF_FFFF_FFFF;
    dinb = 64'h1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      dina = 64'($urandom());
      dinb = 64'($urandom());
      op_sub = ~op_sub;
      in_valid = ~in_valid;
      @(posedge clk);
      #1;
    end
    check("hold.valid0", N'(out_valid), N'(1));
    held = sum;
    for (int i = 0; i < 3; i++) begin
      in_valid = ~in_valid;
      op_sub = ~op_sub;
      dina = 64'($urandom());
      dinb = 64'($urandom());
      @(posedge clk);
      #1;
      check("hold.valid", N'(out_valid), N'(1));
      check("hold.sum", sum, 64'h0);
      check("hold.zero", N'(zero), N'(1));
      check("hold.cout", N'(cout), N'(1));
      check("hold.in_ready", N'(in_ready), N'(0));
    end
    check("hold.first_sum", held, 64'h0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold.delivered", N'(out_valid), N'(0));
    check("hold.idle", N'(in_ready), N'(1));

    // Reset in the middle of RUN.
    in_valid = 1'b1;
    op_sub = 1'b0;
    dina = 64'hFFFF_FFFF_FFFF_FFFF;
    dinb = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midrst.busy_before", N'(busy), N'(1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(vecs[4], "after_rst");

    // Back-to-back with valid and ready held high.
    bb[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1};
    bb[1] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1};
    bb[2] = '{64'h3, 64'h1, 1'b1, 64'h2, 1'b1, 1'b0, 1'b0};
    acc = 0;
    res = 0;
    cyc = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    while (res < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        check($sformatf("b2b%0d.sum", res), sum, bb[res].s);
        check($sformatf("b2b%0d.cout", res), N'(cout), N'(bb[res].co));
        check($sformatf("b2b%0d.zero", res), N'(zero), N'(bb[res].z));
        res++;
      end
      if (in_ready) begin
        if (acc < 3) begin
          dina = bb[acc].a;
          dinb = bb[acc].b;
          op_sub = bb[acc].sub;
          acc_cyc[acc] = cyc;
          acc++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    check("b2b.results", N'(res), N'(3));
    check("b2b.gap01", N'(acc_cyc[1] - acc_cyc[0]), N'(W + 2));
    check("b2b.gap12", N'(acc_cyc[2] - acc_cyc[1]), N'(W + 2));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
